// File: rtl/uncache_wbuf_pkg.sv
// Shared definitions for the uncached-access write buffer.
//   uw_state_e : controller state encoding (IDLE/WR/RD/DONE)
//   *_DEF      : default geometry used by the top-level parameters
//   cnt_width  : width of an occupancy counter able to hold 0..depth
package uncache_wbuf_pkg;

    typedef enum logic [1:0] {
        UW_IDLE = 2'd0,
        UW_WR   = 2'd1,
        UW_RD   = 2'd2,
        UW_DONE = 2'd3
    } uw_state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uncache_wbuf_fifo.sv
// Synchronous FIFO holding posted uncached writes.
// Ports:
//   clk, rst      clock, synchronous active-high reset (discards contents)
//   push, din     enqueue din when not full
//   pop           dequeue head when not empty
//   head          oldest entry, visible combinationally
//   full, empty   occupancy flags
//   count         number of valid entries (0..DEPTH)
module uncache_fifo
    import uncache_wbuf_pkg::*;
#(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array: written on accepted push, never reset (validity tracked by count).
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uncache_wbuf.sv
// Uncached-access controller with a posted-write buffer, sitting beside the
// dcache in MEM. Uncached writes are queued and retired in order without
// stalling the pipeline; uncached reads stall until all queued writes have
// retired and then issue a single AXI read.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cached                        access belongs to the cache; ignored here
//   sram_en/wen/addr/wdata        CPU data-port request (wen==0 means read)
//   sram_rdata                    last uncached read data, held between reads
//   stallreq                      combinational pipeline stall request
//   wbuf_empty                    no queued write and no AXI write in flight
//   axi_en/wsel/addr/wdata        request to the AXI bridge, held until refresh
//   refresh, axi_rdata            bridge completion pulse and read data
//   hit                           one-cycle pulse: sram_rdata carries read data
module uncache_wbuf
    import uncache_wbuf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cached,
    input  logic                  sram_en,
    input  logic [DATA_W/8-1:0]   sram_wen,
    input  logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_W-1:0]     sram_wdata,
    output logic [DATA_W-1:0]     sram_rdata,
    output logic                  stallreq,
    output logic                  wbuf_empty,
    output logic                  axi_en,
    output logic [DATA_W/8-1:0]   axi_wsel,
    output logic [ADDR_W-1:0]     axi_addr,
    output logic [DATA_W-1:0]     axi_wdata,
    input  logic                  refresh,
    input  logic [DATA_W-1:0]     axi_rdata,
    output logic                  hit
);

    localparam int STRB_W = DATA_W / 8;
    localparam int ENT_W  = ADDR_W + DATA_W + STRB_W;
    localparam int CNT_W  = cnt_width(DEPTH);

    uw_state_e         state_r;
    uw_state_e         state_nxt_s;

    logic              axi_en_r;
    logic              axi_en_nxt_s;
    logic [STRB_W-1:0] axi_wsel_r;
    logic [STRB_W-1:0] axi_wsel_nxt_s;
    logic [ADDR_W-1:0] axi_addr_r;
    logic [ADDR_W-1:0] axi_addr_nxt_s;
    logic [DATA_W-1:0] axi_wdata_r;
    logic [DATA_W-1:0] axi_wdata_nxt_s;
    logic [DATA_W-1:0] sram_rdata_r;
    logic [DATA_W-1:0] sram_rdata_nxt_s;
    logic              hit_r;
    logic              hit_nxt_s;

    logic              req_s;
    logic              wr_req_s;
    logic              rd_req_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [ENT_W-1:0]  fifo_din_s;
    logic [ENT_W-1:0]  fifo_head_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;
    logic [STRB_W-1:0] head_strb_s;

    assign req_s    = sram_en & ~cached;
    assign wr_req_s = req_s & (|sram_wen);
    assign rd_req_s = req_s & ~(|sram_wen);

    // A write is accepted whenever the registered occupancy shows room, so a
    // full buffer only frees up for pushes the cycle after a pop.
    assign push_s     = wr_req_s & ~fifo_full_s;
    assign pop_s      = (state_r == UW_WR) & refresh;
    assign fifo_din_s = {sram_addr, sram_wdata, sram_wen};
    assign {head_addr_s, head_data_s, head_strb_s} = fifo_head_s;

    uncache_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Reads are released only in DONE, the one cycle where hit and the data are presented.
    assign stallreq   = ~rst & ((wr_req_s & fifo_full_s) |
                                (rd_req_s & (state_r != UW_DONE)));
    assign wbuf_empty = fifo_empty_s & (state_r != UW_WR);

    assign axi_en     = axi_en_r;
    assign axi_wsel   = axi_wsel_r;
    assign axi_addr   = axi_addr_r;
    assign axi_wdata  = axi_wdata_r;
    assign sram_rdata = sram_rdata_r;
    assign hit        = hit_r;

    // Next-state and next AXI/response register values; writes always drain before any read.
    always_comb begin
        state_nxt_s      = state_r;
        axi_en_nxt_s     = axi_en_r;
        axi_wsel_nxt_s   = axi_wsel_r;
        axi_addr_nxt_s   = axi_addr_r;
        axi_wdata_nxt_s  = axi_wdata_r;
        sram_rdata_nxt_s = sram_rdata_r;
        hit_nxt_s        = 1'b0;
        case (state_r)
            UW_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s     = UW_WR;
                    axi_en_nxt_s    = 1'b1;
                    axi_wsel_nxt_s  = head_strb_s;
                    axi_addr_nxt_s  = head_addr_s;
                    axi_wdata_nxt_s = head_data_s;
                end else if (rd_req_s) begin
                    state_nxt_s     = UW_RD;
                    axi_en_nxt_s    = 1'b1;
                    axi_wsel_nxt_s  = {STRB_W{1'b0}};
                    axi_addr_nxt_s  = sram_addr;
                    axi_wdata_nxt_s = {DATA_W{1'b0}};
                end else begin
                    state_nxt_s = UW_IDLE;
                end
            end
            UW_WR: begin
                if (refresh) begin
                    state_nxt_s     = UW_IDLE;
                    axi_en_nxt_s    = 1'b0;
                    axi_wsel_nxt_s  = {STRB_W{1'b0}};
                    axi_addr_nxt_s  = {ADDR_W{1'b0}};
                    axi_wdata_nxt_s = {DATA_W{1'b0}};
                end else begin
                    state_nxt_s = UW_WR;
                end
            end
            UW_RD: begin
                if (refresh) begin
                    state_nxt_s      = UW_DONE;
                    sram_rdata_nxt_s = axi_rdata;
                    hit_nxt_s        = 1'b1;
                    axi_en_nxt_s     = 1'b0;
                    axi_wsel_nxt_s   = {STRB_W{1'b0}};
                    axi_addr_nxt_s   = {ADDR_W{1'b0}};
                    axi_wdata_nxt_s  = {DATA_W{1'b0}};
                end else begin
                    state_nxt_s = UW_RD;
                end
            end
            UW_DONE: begin
                // The stalled read is released this cycle; returning to IDLE
                // without looking at the request keeps it from relaunching.
                state_nxt_s = UW_IDLE;
            end
            default: begin
                state_nxt_s     = UW_IDLE;
                axi_en_nxt_s    = 1'b0;
                axi_wsel_nxt_s  = {STRB_W{1'b0}};
                axi_addr_nxt_s  = {ADDR_W{1'b0}};
                axi_wdata_nxt_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // State, AXI request and read-response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= UW_IDLE;
            axi_en_r     <= 1'b0;
            axi_wsel_r   <= {STRB_W{1'b0}};
            axi_addr_r   <= {ADDR_W{1'b0}};
            axi_wdata_r  <= {DATA_W{1'b0}};
            sram_rdata_r <= {DATA_W{1'b0}};
            hit_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            axi_en_r     <= axi_en_nxt_s;
            axi_wsel_r   <= axi_wsel_nxt_s;
            axi_addr_r   <= axi_addr_nxt_s;
            axi_wdata_r  <= axi_wdata_nxt_s;
            sram_rdata_r <= sram_rdata_nxt_s;
            hit_r        <= hit_nxt_s;
        end
    end

endmodule

// File: tb/tb_uncache_wbuf.sv
// Directed self-checking bench for uncache_wbuf: inputs change 1 time unit
// after the rising edge, outputs are checked 1-2 time units after that.
module tb_uncache_wbuf;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int STRB_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cached;
    logic              sram_en;
    logic [STRB_W-1:0] sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              stallreq;
    logic              wbuf_empty;
    logic              axi_en;
    logic [STRB_W-1:0] axi_wsel;
    logic [ADDR_W-1:0] axi_addr;
    logic [DATA_W-1:0] axi_wdata;
    logic              refresh;
    logic [DATA_W-1:0] axi_rdata;
    logic              hit;

    logic              man_refresh;
    logic              auto_refresh;
    logic              auto_bridge;
    int                wait_cnt;

    int                errors = 0;
    int                checks = 0;
    logic [67:0]       exp_q [$];
    logic [67:0]       obs_q [$];

    always #5 clk = ~clk;

    assign refresh = auto_bridge ? auto_refresh : man_refresh;

    uncache_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cached     (cached),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .stallreq   (stallreq),
        .wbuf_empty (wbuf_empty),
        .axi_en     (axi_en),
        .axi_wsel   (axi_wsel),
        .axi_addr   (axi_addr),
        .axi_wdata  (axi_wdata),
        .refresh    (refresh),
        .axi_rdata  (axi_rdata),
        .hit        (hit)
    );

    // Record every AXI write the bridge completes, in completion order.
    always @(posedge clk) begin
        if (!rst && refresh && axi_en && (axi_wsel != 4'h0)) begin
            obs_q.push_back({axi_addr, axi_wdata, axi_wsel});
        end
    end

    // Bridge model with random completion latency, active only when enabled.
    initial begin
        auto_refresh = 1'b0;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            auto_refresh = 1'b0;
            if (auto_bridge && axi_en) begin
                if (wait_cnt == 0) begin
                    auto_refresh = 1'b1;
                    wait_cnt = $urandom_range(0, 4);
                end else begin
                    wait_cnt = wait_cnt - 1;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] data);
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = data;
    endtask

    // Complete n AXI operations by hand, waiting a bounded time for each to appear.
    task automatic serve(input int n);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            while (!axi_en && guard < 20) begin
                next_cycle();
                guard++;
            end
            chk("serve_timeout", 68'(guard < 20), 68'd1);
            man_refresh = 1'b1;
            next_cycle();
            man_refresh = 1'b0;
        end
    endtask

    task automatic compare_queues(input string tag);
        int n;
        chk({tag, "_count"}, 68'(obs_q.size()), 68'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_entry"}, obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        cached      = 1'b0;
        man_refresh = 1'b0;
        auto_bridge = 1'b0;
        axi_rdata   = 32'h0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        #1;
        chk("rst_axi_en", 68'(axi_en), 68'd0);
        chk("rst_wbuf_empty", 68'(wbuf_empty), 68'd1);
        chk("rst_hit", 68'(hit), 68'd0);
        chk("rst_stallreq", 68'(stallreq), 68'd0);
        chk("rst_sram_rdata", 68'(sram_rdata), 68'd0);
        rst = 1'b0;
        next_cycle();

        // 1: single posted write
        drive(1'b1, 4'hF, 32'hBFAF_F000, 32'h1234_5678);
        exp_q.push_back({32'hBFAF_F000, 32'h1234_5678, 4'hF});
        #1;
        chk("t1_no_stall", 68'(stallreq), 68'd0);
        next_cycle();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("t1_queued_not_empty", 68'(wbuf_empty), 68'd0);
        chk("t1_axi_en_not_yet", 68'(axi_en), 68'd0);
        next_cycle();
        chk("t1_axi_en", 68'(axi_en), 68'd1);
        chk("t1_axi_addr", 68'(axi_addr), 68'h0BFAF_F000);
        chk("t1_axi_wdata", 68'(axi_wdata), 68'h1234_5678);
        chk("t1_axi_wsel", 68'(axi_wsel), 68'hF);
        man_refresh = 1'b1;
        next_cycle();
        man_refresh = 1'b0;
        #1;
        chk("t1_axi_en_drop", 68'(axi_en), 68'd0);
        chk("t1_axi_addr_clr", 68'(axi_addr), 68'd0);
        chk("t1_wbuf_empty", 68'(wbuf_empty), 68'd1);
        compare_queues("t1_order");

        // 2: five back-to-back writes into a 4-entry buffer, slow bridge
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'hF, 32'hBFAF_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
            exp_q.push_back({32'hBFAF_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF});
            #1;
            chk("t2_push_no_stall", 68'(stallreq), 68'd0);
            next_cycle();
        end
        drive(1'b1, 4'hF, 32'hBFAF_0010, 32'hA000_0004);
        exp_q.push_back({32'hBFAF_0010, 32'hA000_0004, 4'hF});
        #1;
        chk("t2_full_stall", 68'(stallreq), 68'd1);
        repeat (8) next_cycle();
        chk("t2_still_stalled", 68'(stallreq), 68'd1);
        chk("t2_head_held", 68'(axi_addr), 68'h0BFAF_0000);
        man_refresh = 1'b1;
        #1;
        chk("t2_stall_during_pop", 68'(stallreq), 68'd1);
        next_cycle();
        man_refresh = 1'b0;
        #1;
        chk("t2_stall_release", 68'(stallreq), 68'd0);
        next_cycle();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        serve(4);
        #1;
        chk("t2_drained", 68'(wbuf_empty), 68'd1);
        compare_queues("t2_order");

        // 3: read behind two queued writes
        drive(1'b1, 4'h3, 32'hBFD0_1000, 32'h1111_1111);
        exp_q.push_back({32'hBFD0_1000, 32'h1111_1111, 4'h3});
        next_cycle();
        drive(1'b1, 4'hC, 32'hBFD0_1004, 32'h2222_2222);
        exp_q.push_back({32'hBFD0_1004, 32'h2222_2222, 4'hC});
        next_cycle();
        drive(1'b1, 4'h0, 32'hBFD0_0000, 32'h0);
        #1;
        chk("t3_read_stall", 68'(stallreq), 68'd1);
        chk("t3_first_is_write", 68'(axi_wsel), 68'h3);
        serve(2);
        #1;
        chk("t3_stall_after_writes", 68'(stallreq), 68'd1);
        next_cycle();
        chk("t3_rd_axi_en", 68'(axi_en), 68'd1);
        chk("t3_rd_addr", 68'(axi_addr), 68'h0BFD0_0000);
        chk("t3_rd_wsel", 68'(axi_wsel), 68'd0);
        chk("t3_rd_stall", 68'(stallreq), 68'd1);
        axi_rdata   = 32'hCAFE_F00D;
        man_refresh = 1'b1;
        next_cycle();
        man_refresh = 1'b0;
        axi_rdata   = 32'h0;
        #1;
        chk("t3_hit", 68'(hit), 68'd1);
        chk("t3_rdata", 68'(sram_rdata), 68'hCAFE_F00D);
        chk("t3_done_no_stall", 68'(stallreq), 68'd0);
        chk("t3_axi_en_drop", 68'(axi_en), 68'd0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        chk("t3_hit_pulse", 68'(hit), 68'd0);
        chk("t3_rdata_held", 68'(sram_rdata), 68'hCAFE_F00D);
        chk("t3_no_relaunch", 68'(axi_en), 68'd0);
        compare_queues("t3_order");

        // 4: cached accesses are ignored
        cached = 1'b1;
        drive(1'b1, 4'hF, 32'h0000_1000, 32'h5555_AAAA);
        #1;
        chk("t4_wr_no_stall", 68'(stallreq), 68'd0);
        next_cycle();
        chk("t4_wr_no_axi", 68'(axi_en), 68'd0);
        chk("t4_wr_no_push", 68'(wbuf_empty), 68'd1);
        drive(1'b1, 4'h0, 32'h0000_2000, 32'h0);
        #1;
        chk("t4_rd_no_stall", 68'(stallreq), 68'd0);
        next_cycle();
        next_cycle();
        chk("t4_rd_no_axi", 68'(axi_en), 68'd0);
        cached = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();

        // 5: reset in the middle of a read, then with three writes pending
        drive(1'b1, 4'h0, 32'hBFD0_0010, 32'h0);
        next_cycle();
        chk("t5_rd_issued", 68'(axi_en), 68'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_masks_stall", 68'(stallreq), 68'd0);
        next_cycle();
        chk("t5_rd_axi_en_drop", 68'(axi_en), 68'd0);
        chk("t5_rd_wbuf_empty", 68'(wbuf_empty), 68'd1);
        chk("t5_rd_hit", 68'(hit), 68'd0);
        chk("t5_rdata_cleared", 68'(sram_rdata), 68'd0);
        rst = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hF, 32'hBFE0_0000 + 32'(i * 4), 32'hDEAD_0000 + 32'(i));
            next_cycle();
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("t5_wr_pending", 68'(wbuf_empty), 68'd0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("t5_wr_axi_en_drop", 68'(axi_en), 68'd0);
        chk("t5_wr_wbuf_empty", 68'(wbuf_empty), 68'd1);
        repeat (5) next_cycle();
        chk("t5_no_stale_write", 68'(axi_en), 68'd0);
        chk("t5_still_empty", 68'(wbuf_empty), 68'd1);
        compare_queues("t5_none");

        // 6: pointer wrap with random bridge latency
        auto_bridge = 1'b1;
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  w;
            int          guard;
            a = 32'hBFC0_0000 + 32'($urandom_range(0, 255) * 4);
            d = 32'($urandom);
            w = 4'($urandom_range(1, 15));
            drive(1'b1, w, a, d);
            exp_q.push_back({a, d, w});
            #1;
            guard = 0;
            while (stallreq && guard < 50) begin
                next_cycle();
                #1;
                guard++;
            end
            chk("t6_stall_timeout", 68'(guard < 50), 68'd1);
            next_cycle();
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        begin
            int guard = 0;
            while (!wbuf_empty && guard < 200) begin
                next_cycle();
                guard++;
            end
            chk("t6_drain_timeout", 68'(guard < 200), 68'd1);
        end
        auto_bridge = 1'b0;
        compare_queues("t6_order");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
